csa_tree_pipe: RTL and testbench

- Pipelined, handshaked carry-save compression tree for the dot-product datapath.
- Reduces N operands to a redundant sum/carry pair plus a resolved total, with a configurable number of register stages.
- Adds per-operand masking, runtime signed/unsigned extension and tag passthrough.
- Sits between the partial-product/alignment stage and the accumulator/normaliser; accepts one vector per cycle at full throughput.

---
 rtl/csa_tree_pipe.sv | 168 ++++++++++++++++
 tb/tb_csa_tree_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: masked, sign-selectable N-operand carry-save reduction tree.
// The tree is purely combinational. It feeds an elastic chain of STAGES
// sum/carry/tag registers. A final carry-propagate adder resolves the
// registered sum/carry pair into result_o.
module csa_tree_pipe #(
    parameter int N       = 8,
    parameter int WIDTH_I = 8,
    parameter int WIDTH_O = WIDTH_I + $clog2(N),
    parameter int STAGES  = 2,
    parameter int TAG_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [N*WIDTH_I-1:0]   operands_i,
    input  logic [N-1:0]           mask_i,
    input  logic                   signed_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_O-1:0]     sum_o,
    output logic [WIDTH_O-1:0]     carry_o,
    output logic [WIDTH_O-1:0]     result_o,
    output logic [TAG_W-1:0]       tag_o
);

    // Two spare slots, so the group-of-three reads in the tree never index past the end.
    localparam int SLOTS = N + 2;

    logic [N*WIDTH_O-1:0]     ext_ops;
    logic [SLOTS*WIDTH_O-1:0] work;
    logic [SLOTS*WIDTH_O-1:0] nxt;
    logic [WIDTH_O-1:0]       a, b, c;
    logic [WIDTH_O-1:0]       tree_sum;
    logic [WIDTH_O-1:0]       tree_carry;
    int                       cnt;
    int                       ncnt;

    // Masked operands become zero. The others are extended to WIDTH_O according to the beat's signed_i.
    always_comb begin
        ext_ops = '0;
        for (int k = 0; k < N; k++) begin
            if (mask_i[k]) begin
                if (signed_i)
                    ext_ops[k*WIDTH_O +: WIDTH_O] = WIDTH_O'($signed(operands_i[k*WIDTH_I +: WIDTH_I]));
                else
                    ext_ops[k*WIDTH_O +: WIDTH_O] = WIDTH_O'(operands_i[k*WIDTH_I +: WIDTH_I]);
            end
        end
    end

    // Wallace-style reduction. Each level replaces every full group of three
    // rows with a 3:2 compressor (sum, carry<<1). Leftover rows pass through.
    // The loop stops at two rows. Slots beyond the live row count stay zero, so
    // N=1 and N=2 fall straight through as sum/carry.
    always_comb begin
        work                  = '0;
        work[N*WIDTH_O-1:0]   = ext_ops;
        cnt                   = N;
        nxt                   = '0;
        ncnt                  = 0;
        a                     = '0;
        b                     = '0;
        c                     = '0;
        for (int l = 0; l < N; l++) begin
            if (cnt > 2) begin
                nxt  = '0;
                ncnt = 0;
                for (int g = 0; g < N; g += 3) begin
                    if (g + 2 < cnt) begin
                        a = work[g*WIDTH_O +: WIDTH_O];
                        b = work[(g+1)*WIDTH_O +: WIDTH_O];
                        c = work[(g+2)*WIDTH_O +: WIDTH_O];
                        nxt[ncnt*WIDTH_O +: WIDTH_O]     = a ^ b ^ c;
                        nxt[(ncnt+1)*WIDTH_O +: WIDTH_O] = ((a & b) | (a & c) | (b & c)) << 1;
                        ncnt = ncnt + 2;
                    end else if (g < cnt) begin
                        nxt[ncnt*WIDTH_O +: WIDTH_O]     = work[g*WIDTH_O +: WIDTH_O];
                        nxt[(ncnt+1)*WIDTH_O +: WIDTH_O] = work[(g+1)*WIDTH_O +: WIDTH_O];
                        ncnt = ncnt + ((g + 1 < cnt) ? 2 : 1);
                    end
                end
                work = nxt;
                cnt  = ncnt;
            end
        end
    end

    assign tree_sum   = work[0 +: WIDTH_O];
    assign tree_carry = work[WIDTH_O +: WIDTH_O];

    generate
        if (STAGES == 0) begin : g_comb
            assign valid_o = valid_i;
            assign ready_o = ready_i;
            assign sum_o   = tree_sum;
            assign carry_o = tree_carry;
            assign tag_o   = tag_i;
        end else begin : g_pipe
            logic [STAGES-1:0]                  vld_q, vld_d, load;
            logic [STAGES-1:0][WIDTH_O-1:0]     sum_q, sum_d, carry_q, carry_d;
            logic [STAGES-1:0][TAG_W-1:0]       tag_q, tag_d;
            // Index 0 is the tree output. Index s+1 is stage s. Index STAGES is the block output.
            logic [STAGES:0]                    vld_pipe;
            logic [STAGES:0][WIDTH_O-1:0]       sum_pipe, carry_pipe;
            logic [STAGES:0][TAG_W-1:0]         tag_pipe;
            logic                               acc;

            assign vld_pipe   = {vld_q, valid_i};
            assign sum_pipe   = {sum_q, tree_sum};
            assign carry_pipe = {carry_q, tree_carry};
            assign tag_pipe   = {tag_q, tag_i};

            // A stage may load if it or any later stage is empty, or if the consumer is taking the head.
            always_comb begin
                acc  = ready_i;
                load = '0;
                for (int s = STAGES - 1; s >= 0; s--) begin
                    acc     = acc | ~vld_q[s];
                    load[s] = acc;
                end
            end

            // Loading stages take their predecessor. Data moves only with a valid beat.
            always_comb begin
                vld_d   = vld_q;
                sum_d   = sum_q;
                carry_d = carry_q;
                tag_d   = tag_q;
                for (int s = 0; s < STAGES; s++) begin
                    if (load[s]) begin
                        vld_d[s] = vld_pipe[s];
                        if (vld_pipe[s]) begin
                            sum_d[s]   = sum_pipe[s];
                            carry_d[s] = carry_pipe[s];
                            tag_d[s]   = tag_pipe[s];
                        end
                    end
                end
            end

            // Stage registers. Reset empties the pipe and zeroes all data.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    vld_q   <= '0;
                    sum_q   <= '0;
                    carry_q <= '0;
                    tag_q   <= '0;
                end else begin
                    vld_q   <= vld_d;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    tag_q   <= tag_d;
                end
            end

            assign ready_o = load[0];
            assign valid_o = vld_pipe[STAGES];
            assign sum_o   = sum_pipe[STAGES];
            assign carry_o = carry_pipe[STAGES];
            assign tag_o   = tag_pipe[STAGES];
        end
    endgenerate

    assign result_o = sum_o + carry_o;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe. It drives a STAGES=2 instance and a STAGES=0
// instance from shared inputs. Both are checked against an integer-sum
// reference model and a scoreboard queue.
module tb_csa_tree_pipe;
    localparam int N  = 8;
    localparam int WI = 8;
    localparam int WO = 11;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, valid_i, sgn, ready_i;
    logic [N*WI-1:0]   ops;
    logic [N-1:0]      mask;
    logic [TW-1:0]     tag;

    logic              rdy_o, vld_o;
    logic [WO-1:0]     sum_o, car_o, res_o;
    logic [TW-1:0]     tag_o;
    logic              rdy0_o, vld0_o;
    logic [WO-1:0]     sum0_o, car0_o, res0_o;
    logic [TW-1:0]     tag0_o;

    csa_tree_pipe #(.N(N), .WIDTH_I(WI), .STAGES(2), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy_o),
        .operands_i(ops), .mask_i(mask), .signed_i(sgn), .tag_i(tag),
        .valid_o(vld_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(car_o),
        .result_o(res_o), .tag_o(tag_o));

    csa_tree_pipe #(.N(N), .WIDTH_I(WI), .STAGES(0), .TAG_W(TW)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy0_o),
        .operands_i(ops), .mask_i(mask), .signed_i(sgn), .tag_i(tag),
        .valid_o(vld0_o), .ready_i(ready_i), .sum_o(sum0_o), .carry_o(car0_o),
        .result_o(res0_o), .tag_o(tag0_o));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: add up the operands as plain integers, then wrap to WO bits.
    function automatic logic [WO-1:0] ref_sum(input logic [N*WI-1:0] o,
                                              input logic [N-1:0] m, input logic s);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                int v;
                v = int'(o[k*WI +: WI]);
                if (s && v >= (1 << (WI - 1))) v -= (1 << WI);
                acc += v;
            end
        end
        return WO'(acc);
    endfunction

    typedef struct {
        logic [WO-1:0] res;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [TW-1:0] tags_out[$];
    int            cyc = 0;
    int            last_stall = -1;
    bit            checks_on = 0, was_rst = 0, stall_prev = 0, saw_rdy_low = 0;
    logic [WO-1:0] sv_sum, sv_car, sv_res;
    logic [TW-1:0] sv_tag;

    // Compare process. It samples at negedge, where the inputs equal what the next posedge will see.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            stall_prev = 0;
            was_rst    = 1;
            checks_on  = 1;
        end else if (checks_on) begin
            if (was_rst) begin
                chk("rst_valid", 32'(vld_o), 32'd0);
                chk("rst_sum",   32'(sum_o), 32'd0);
                chk("rst_carry", 32'(car_o), 32'd0);
                chk("rst_res",   32'(res_o), 32'd0);
                chk("rst_tag",   32'(tag_o), 32'd0);
            end
            was_rst = 0;
            if (!ready_i) last_stall = cyc;
            if (!rdy_o) saw_rdy_low = 1;
            chk("ready_o", 32'(rdy_o), 32'((q.size() < 2) || ready_i));
            if (stall_prev) begin
                chk("stall_valid", 32'(vld_o), 32'd1);
                chk("stall_sum",   32'(sum_o), 32'(sv_sum));
                chk("stall_carry", 32'(car_o), 32'(sv_car));
                chk("stall_res",   32'(res_o), 32'(sv_res));
                chk("stall_tag",   32'(tag_o), 32'(sv_tag));
            end
            if (vld_o) chk("cpa", 32'(WO'(sum_o + car_o)), 32'(res_o));
            if (vld_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", 32'(res_o), 32'(e.res));
                    chk("tag",    32'(tag_o), 32'(e.tag));
                    if (last_stall < e.cyc) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    tags_out.push_back(tag_o);
                end
            end
            // The combinational instance must track its inputs within the same cycle.
            chk("s0_valid", 32'(vld0_o), 32'(valid_i));
            chk("s0_ready", 32'(rdy0_o), 32'(ready_i));
            if (valid_i) begin
                chk("s0_result", 32'(res0_o), 32'(ref_sum(ops, mask, sgn)));
                chk("s0_tag",    32'(tag0_o), 32'(tag));
                chk("s0_cpa",    32'(WO'(sum0_o + car0_o)), 32'(res0_o));
            end
            stall_prev = vld_o && !ready_i;
            sv_sum = sum_o; sv_car = car_o; sv_res = res_o; sv_tag = tag_o;
            if (valid_i && rdy_o) q.push_back('{ref_sum(ops, mask, sgn), tag, cyc});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until the pipe accepts it. Returns one step after the accepting edge.
    task automatic send(input logic [N*WI-1:0] o, input logic [N-1:0] m,
                        input logic s, input logic [TW-1:0] t);
        bit acc;
        int n;
        valid_i = 1'b1; ops = o; mask = m; sgn = s; tag = t;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy_o;
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N*WI-1:0] p2;
        logic [N*WI-1:0] p3;
        rst_n = 1'b0; valid_i = 1'b0; ops = '0; mask = '0; sgn = 1'b0; tag = '0; ready_i = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: all 0xFF unsigned -> 2040, two-cycle latency
        valid_i = 1'b1; ops = {N{8'hFF}}; mask = 8'hFF; sgn = 1'b0; tag = 4'd5;
        tick();
        valid_i = 1'b0;
        @(negedge clk); chk("t1_not_early", 32'(vld_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_valid", 32'(vld_o), 32'd1);
        chk("t1_res",   32'(res_o), 32'h7F8);
        chk("t1_tag",   32'(tag_o), 32'd5);
        tick();

        // 2: the same operands unsigned then signed, back-to-back
        p2 = {8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80};
        valid_i = 1'b1; ops = p2; mask = 8'hFF; sgn = 1'b0; tag = 4'd1;
        tick();
        sgn = 1'b1; tag = 4'd2;
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("t2_valid_u", 32'(vld_o), 32'd1);
        chk("t2_res_u",   32'(res_o), 32'h204);
        tick();
        @(negedge clk);
        chk("t2_valid_s", 32'(vld_o), 32'd1);
        chk("t2_res_s",   32'(res_o), 32'h604);
        tick();

        // 3: partial mask and full mask-off
        p3 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        valid_i = 1'b1; ops = p3; mask = 8'h0F; sgn = 1'b0; tag = 4'd3;
        tick();
        mask = 8'h00; tag = 4'd4;
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("t3_res_0f", 32'(res_o), 32'd10);
        tick();
        @(negedge clk);
        chk("t3_valid_00", 32'(vld_o), 32'd1);
        chk("t3_res_00",   32'(res_o), 32'd0);
        tick();

        // 4: six beats streamed while the downstream stalls mid-stream
        tags_out.delete();
        saw_rdy_low = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    tick();
                    ready_i = !(k >= 2 && k <= 5);
                end
            end
        join_none
        for (int i = 0; i < 6; i++)
            send({$urandom, $urandom}, N'($urandom), 1'($urandom), TW'(i));
        valid_i = 1'b0;
        repeat (15) tick();
        chk("t4_ready_fell", 32'(saw_rdy_low), 32'd1);
        chk("t4_count", 32'(tags_out.size()), 32'd6);
        for (int i = 0; i < 6 && i < tags_out.size(); i++)
            chk("t4_order", 32'(tags_out[i]), 32'(i));

        // 5: reset with two beats in flight, then one clean beat
        ready_i = 1'b0;
        valid_i = 1'b1; ops = {N{8'h33}}; mask = 8'hFF; sgn = 1'b0; tag = 4'd7;
        tick();
        tag = 4'd8;
        tick();
        valid_i = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(vld_o), 32'd0);
        chk("t5_res",   32'(res_o), 32'd0);
        chk("t5_tag",   32'(tag_o), 32'd0);
        chk("t5_ready", 32'(rdy_o), 32'd1);
        tick();
        valid_i = 1'b1; ops = {N{8'h10}}; mask = 8'hFF; sgn = 1'b0; tag = 4'd9;
        tick();
        valid_i = 1'b0;
        @(negedge clk); chk("t5_not_early", 32'(vld_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_post_valid", 32'(vld_o), 32'd1);
        chk("t5_post_res",   32'(res_o), 32'h080);
        chk("t5_post_tag",   32'(tag_o), 32'd9);
        tick();

        // 6: random traffic with ready_i toggling. Both instances are checked by the compare process.
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ops     = {$urandom, $urandom};
            mask    = N'($urandom);
            sgn     = 1'($urandom);
            tag     = TW'($urandom);
            ready_i = ($urandom_range(0, 9) < 6);
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (5) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
